// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared constants and types for the SHA-256 digest read-out path.
//   WORD_W    : width of one streamed hash word
//   NUM_WORDS : hash words per digest (H0..H7)
//   CNT_W     : word-counter width, clog2(NUM_WORDS)
//   DIGEST_W  : full digest width
//   state_t   : read-out FSM states
//   bswap_word: byte reversal used by the little-endian build
package sha256_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int CNT_W     = 3;
    localparam int DIGEST_W  = WORD_W * NUM_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] bswap_word(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/sha256_digest_reader_if.sv
// sha256_digest_reader_if
// Bundles the control inputs, the captured-digest input and the word stream
// of the digest reader.
//   master : host side (drives start/abort/digest_i/out_ready)
//   slave  : reader side (drives out_data/out_valid/out_last/busy/done/dbg_state)
// Stream handshake: a word moves when out_valid and out_ready are both high
// in the same cycle; once out_valid is raised it stays high with out_data
// unchanged until that transfer happens (or abort/reset ends the stream).
interface sha256_digest_reader_if;
    import sha256_pkg::*;

    logic                start;
    logic                abort;
    logic [DIGEST_W-1:0] digest_i;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;
    logic                done;
    state_t              dbg_state;

    modport master (
        output start, abort, digest_i, out_ready,
        input  out_data, out_valid, out_last, busy, done, dbg_state
    );

    modport slave (
        input  start, abort, digest_i, out_ready,
        output out_data, out_valid, out_last, busy, done, dbg_state
    );
endinterface

// File: rtl/digest_shift_reg.sv
// digest_shift_reg
// Parallel-load register that shifts left by one word, filling with zeros
// from the LSB side. Load takes priority over shift.
//   CLK, RST     : clock, asynchronous active-low reset
//   i_load, i_d  : load the full digest
//   i_shift      : shift left by one word
//   o_top_word   : most significant word (next word to send)
module digest_shift_reg
    import sha256_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_load,
    input  logic                i_shift,
    input  logic [DIGEST_W-1:0] i_d,
    output logic [WORD_W-1:0]   o_top_word
);
    logic [DIGEST_W-1:0] r_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_d;
        end else if (i_shift) begin
            r_data <= {r_data[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    assign o_top_word = r_data[DIGEST_W-1 -: WORD_W];
endmodule

// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader
// Captures the final SHA-256 state H0..H7 on start and streams it out one
// word per handshake, H0 first, followed by a one-cycle done pulse.
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : sha256_digest_reader_if.slave (start, abort, digest_i, out_ready in;
//         out_data, out_valid, out_last, busy, done, dbg_state out)
// Build option: DIGEST_BSWAP_EN byte-reverses each output word (little-endian
// host order); handshake and timing are unchanged.
module sha256_digest_reader
    import sha256_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    sha256_digest_reader_if.slave  bus
);
    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_capture;
    logic               w_xfer;
    logic               w_last;
    logic [WORD_W-1:0]  w_top_word;
    logic [WORD_W-1:0]  w_word;

    // Abort beats start, so a same-cycle abort suppresses the capture.
    assign w_capture = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_last    = (r_cnt == CNT_W'(NUM_WORDS - 1));
    // An aborted cycle never counts as a transfer, even if out_ready is high.
    assign w_xfer    = (r_state == SEND) && bus.out_ready && !bus.abort;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start) w_next_state = SEND;
                SEND:    if (bus.out_ready && w_last) w_next_state = DONE;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // The final transfer clears the counter instead of letting it wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (bus.abort || w_capture) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    digest_shift_reg u_shift (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_capture),
        .i_shift    (w_xfer),
        .i_d        (bus.digest_i),
        .o_top_word (w_top_word)
    );

`ifdef DIGEST_BSWAP_EN
    assign w_word = bswap_word(w_top_word);
`else
    assign w_word = w_top_word;
`endif

    // out_data is forced to zero outside SEND so a partially shifted digest
    // left behind by an abort never appears on the bus.
    assign bus.out_valid = (r_state == SEND);
    assign bus.out_data  = bus.out_valid ? w_word : '0;
    assign bus.out_last  = bus.out_valid && w_last;
    assign bus.busy      = (r_state == SEND) || (r_state == DONE);
    assign bus.done      = (r_state == DONE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sha256_digest_reader.sv
module tb_sha256_digest_reader;
    import sha256_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sha256_digest_reader_if bus ();

    sha256_digest_reader dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] seen_first;
    logic [WORD_W-1:0] seen_last;

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
`ifdef DIGEST_BSWAP_EN
    localparam logic [31:0] ABC_FIRST = 32'hbf1678ba;
    localparam logic [31:0] ABC_LAST  = 32'had1500f2;
`else
    localparam logic [31:0] ABC_FIRST = 32'hba7816bf;
    localparam logic [31:0] ABC_LAST  = 32'hf20015ad;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word i of the digest as the host should see it: H0 is the top 32 bits.
    function automatic logic [WORD_W-1:0] model_word(input logic [255:0] dig, input int i);
        logic [WORD_W-1:0] w;
        w = dig[255 - 32*i -: 32];
`ifdef DIGEST_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"},  bus.out_data, 0);
        check({tag, "_last"},  bus.out_last, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready.
    // abort_at >= 0: abort once that many words have transferred.
    // poke: re-pulse start and overwrite digest_i with all-ones mid-stream.
    task automatic run_stream(input logic [255:0] dig, input int mode, input int abort_at,
                              input bit poke, output int ncyc);
        int  xfers;
        int  k;
        bit  rdy;
        xfers = 0;
        k     = 0;
        exp_q.delete();
        for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back(model_word(dig, i));

        bus.digest_i  = dig;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        step();
        ncyc = 1;
        bus.start = 1'b0;
        check("first_valid", bus.out_valid, 1);
        seen_first = bus.out_data;

        while (exp_q.size() > 0 && ncyc < 200) begin
            check("valid", bus.out_valid, 1);
            check("busy", bus.busy, 1);
            check("early_done", bus.done, 0);
            check("data", bus.out_data, exp_q[0]);
            check("last", bus.out_last, exp_q.size() == 1);
            if (exp_q.size() == 1) seen_last = bus.out_data;

            if (poke && ncyc == 2) begin
                bus.start    = 1'b1;
                bus.digest_i = '1;
            end else begin
                bus.start = 1'b0;
            end

            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            k++;

            if (abort_at >= 0 && xfers == abort_at) begin
                bus.abort     = 1'b1;
                bus.out_ready = 1'($urandom_range(0, 1));
                step();
                bus.abort     = 1'b0;
                bus.out_ready = 1'b0;
                bus.start     = 1'b0;
                check_idle_outputs("abort");
                check("abort_state", bus.dbg_state, IDLE);
                return;
            end

            bus.out_ready = rdy;
            step();
            ncyc++;
            if (rdy) begin
                void'(exp_q.pop_front());
                xfers++;
            end
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("xfer_count", xfers, NUM_WORDS);

        check("done_pulse", bus.done, 1);
        check("done_valid", bus.out_valid, 0);
        check("done_busy", bus.busy, 1);
        check("done_last", bus.out_last, 0);
        step();
        check_idle_outputs("after_done");
    endtask

    int ncyc;

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.digest_i  = '0;
        bus.out_ready = 1'b0;
        seen_first    = '0;
        seen_last     = '0;

        repeat (2) step();
        check_idle_outputs("reset");
        check("reset_state", bus.dbg_state, IDLE);
        rst_n = 1'b1;
        step();

        // Basic stream with ready held high: start edge, 8 transfer edges,
        // then the DONE cycle is observed after 9 edges (10 cycles inclusive).
        run_stream(ABC, 0, -1, 1'b0, ncyc);
        check("abc_latency", ncyc, NUM_WORDS + 1);
        check("abc_first", seen_first, ABC_FIRST);
        check("abc_last", seen_last, ABC_LAST);

        // Backpressure pattern.
        run_stream(ABC, 1, -1, 1'b0, ncyc);

        // Restart and digest change during SEND must not disturb the stream.
        run_stream(ABC, 0, -1, 1'b1, ncyc);
        bus.digest_i = '0;

        // Abort after the 3rd transfer, then a fresh stream from H0.
        run_stream(ABC, 0, 3, 1'b0, ncyc);
        step();
        check_idle_outputs("post_abort");
        run_stream(rand_digest(), 0, -1, 1'b0, ncyc);

        // Abort and start together in IDLE: no capture.
        bus.digest_i = rand_digest();
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle_outputs("abort_start");
        step();
        check_idle_outputs("abort_start2");

        // Asynchronous reset between clock edges mid-stream.
        bus.digest_i  = ABC;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();
        check("pre_reset_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_state", bus.dbg_state, IDLE);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_outputs("no_resume");
        end
        bus.out_ready = 1'b0;

        // Randomized streams, some aborted.
        for (int t = 0; t < 8; t++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_WORDS - 1)) : -1;
            run_stream(rand_digest(), 2, ab, 1'($urandom_range(0, 1)), ncyc);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sha256_digest_reader.md
Name: sha256_digest_reader

Overview:
Read side of the hash-state registers. Captures the final 256-bit SHA-256 state H0..H7 on a start pulse, then streams it out one 32-bit word per handshake on a valid/ready interface, H0 first. Sits between the hash-state register bank and the host/bus interface. Signals completion with a one-cycle done pulse.

Parameters:
WORD_W, 32, width of one output word in bits
NUM_WORDS, 8, number of hash words per digest
CNT_W, 3, word-counter width; must equal clog2(NUM_WORDS)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset; RST=0 clears all state immediately
start  input  1  capture request; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE, no done pulse
digest_i  input  WORD_W*NUM_WORDS  hash state; H0 in [255:224], H7 in [31:0]
out_data  output  WORD_W  current output word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word when out_valid=1
out_last  output  1  high with out_valid while the final word (H7) is presented
busy  output  1  high in SEND and DONE
done  output  1  one-cycle pulse after the final word is transferred

Behaviour:
- Reset values (RST=0, asynchronous): state=IDLE, shift register=0, counter=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
- Reset asserted mid-stream aborts immediately. There is no resume after reset.
- FSM states are IDLE, SEND and DONE.
- IDLE:
  - If start=1 and abort=0, latch digest_i into the shift register, clear the counter and go to SEND.
  - out_valid rises on the next cycle: one cycle of latency from start to the first valid word.
- SEND:
  - out_valid=1 and out_data = top word of the shift register.
  - A transfer occurs when out_valid=1 and out_ready=1 in the same cycle.
  - On a transfer: shift left by WORD_W, counter+1.
  - With out_ready held at 1, one word is transferred per cycle.
  - out_ready=0 stalls the stream. out_data and out_valid stay stable; out_valid is never withdrawn without a transfer.
  - out_last = (counter == NUM_WORDS-1).
  - A transfer while out_last=1 moves the FSM to DONE.
- DONE:
  - done=1 and out_valid=0 for exactly one cycle, then the FSM goes to IDLE.
- start outside IDLE is ignored; digest_i is not re-latched.
- digest_i changing after capture has no effect on the output.
- abort=1 in any state moves the FSM to IDLE next cycle with out_valid=0, no done pulse, and counter cleared.
- abort and start in the same IDLE cycle: abort wins and there is no capture.
- The counter never wraps within a stream. It is cleared on capture and abort.
- The shift register fills with zeros from the LSB side.
- Minimum stream length is NUM_WORDS+2 cycles from start to done, given out_ready held at 1.

Optional Feature:
Macro DIGEST_BSWAP_EN.
- Defined: each out_data word is byte-reversed, i.e. out_data = {w[7:0], w[15:8], w[23:16], w[31:24]}, giving little-endian byte order for the host bus. Valid only when WORD_W=32.
- Not defined: out_data is the big-endian word exactly as held in the H register.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package sha256_pkg holds WORD_W, NUM_WORDS, DIGEST_W (=256) and the FSM state enum {IDLE, SEND, DONE}.
- One sub-module, digest_shift_reg: a parallel-load, shift-by-word register with load/shift enables. The FSM, counter and optional byte-swap stay in the top module.

Test Plan:
- Basic stream: digest_i = SHA-256("abc") = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, pulse start, out_ready=1. Required: 8 consecutive words in that order, first valid 1 cycle after start, out_last only on f20015ad, done pulse on the cycle after.
- Backpressure: same digest, out_ready toggling 1,0,0,1,... Required: each word held stable while out_ready=0, no word lost or duplicated, done only after the 8th transfer.
- Ignored start/capture isolation: start pulsed again and digest_i changed to all-ones during SEND. Required: stream still outputs the "abc" words and busy stays 1.
- Abort: abort=1 after the 3rd transfer. Required: out_valid=0 next cycle, no done pulse, IDLE; a following start streams the new digest from H0.
- Async reset: drive RST=0 between clock edges mid-stream. Required: all outputs go to 0 immediately. After RST=1, no output until the next start.
- DIGEST_BSWAP_EN build: "abc" digest. Required: first word bf1678ba, last word ad1500f2.
